// File: rtl/qspi_arbiter.sv
// Two-requester round-robin arbiter in front of a single-outstanding QSPI read port.
// Define QSPI_ARB_TIMEOUT_EN to build in the WAIT timeout counter and error flag.
module qspi_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        m0_req_valid,
  output logic        m0_req_ready,
  input  logic [23:0] m0_req_addr,
  output logic        m0_rsp_valid,
  input  logic        m0_rsp_ready,
  output logic [31:0] m0_rsp_data,
  output logic        m0_rsp_err,
  input  logic        m1_req_valid,
  output logic        m1_req_ready,
  input  logic [23:0] m1_req_addr,
  output logic        m1_rsp_valid,
  input  logic        m1_rsp_ready,
  output logic [31:0] m1_rsp_data,
  output logic        m1_rsp_err,
  output logic [23:0] qspi_addr,
  output logic        qspi_read_en,
  input  logic [31:0] qspi_dout,
  input  logic        qspi_dval,
  output logic        qspi_rready
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [23:0] addr_q;
  logic [31:0] data_q;
  logic        gnt_q;
  logic        last_q;
  logic        win0;
  logic        win1;
  logic        to_hit;
  logic        rsp_hs;

  // last_q = 1 means m1 was granted last, so m0 wins a tie
  assign win0 = m0_req_valid & (~m1_req_valid | last_q);
  assign win1 = m1_req_valid & (~m0_req_valid | ~last_q);

  assign rsp_hs = (state == RESP) &
                  (gnt_q ? m1_rsp_ready : m0_rsp_ready);

`ifdef QSPI_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q;
  logic          err_q;

  assign to_hit = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      unique case (state)
        ISSUE: cnt_q <= '0;
        WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (qspi_dval) begin
            err_q <= 1'b0;
          end else if (to_hit) begin
            err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign m0_rsp_err = (state == RESP) & ~gnt_q & err_q;
  assign m1_rsp_err = (state == RESP) & gnt_q & err_q;
`else
  assign to_hit     = 1'b0;
  assign m0_rsp_err = 1'b0;
  assign m1_rsp_err = 1'b0;
`endif

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state  <= IDLE;
      addr_q <= '0;
      data_q <= '0;
      gnt_q  <= 1'b0;
      last_q <= 1'b1;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (win0 | win1) begin
            addr_q <= win0 ? m0_req_addr : m1_req_addr;
            gnt_q  <= win1;
          end
        end
        WAIT: begin
          if (qspi_dval) begin
            data_q <= qspi_dout;
          end else if (to_hit) begin
            data_q <= '0;
          end
        end
        RESP: begin
          if (rsp_hs) begin
            last_q <= gnt_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx     = state;
    m0_req_ready = 1'b0;
    m1_req_ready = 1'b0;
    m0_rsp_valid = 1'b0;
    m1_rsp_valid = 1'b0;
    m0_rsp_data  = '0;
    m1_rsp_data  = '0;
    qspi_addr    = '0;
    qspi_read_en = 1'b0;
    qspi_rready  = 1'b0;
    unique case (state)
      IDLE: begin
        m0_req_ready = win0;
        m1_req_ready = win1;
        if (win0 | win1) begin
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        qspi_addr    = addr_q;
        qspi_read_en = 1'b1;
        state_nx     = WAIT;
      end
      WAIT: begin
        qspi_addr   = addr_q;
        qspi_rready = 1'b1;
        if (qspi_dval | to_hit) begin
          state_nx = RESP;
        end
      end
      RESP: begin
        if (gnt_q) begin
          m1_rsp_valid = 1'b1;
          m1_rsp_data  = data_q;
        end else begin
          m0_rsp_valid = 1'b1;
          m0_rsp_data  = data_q;
        end
        if (rsp_hs) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_qspi_arbiter.sv
// Self-checking bench for qspi_arbiter: per-cycle transaction model plus directed cases.
// Timeout case runs only when QSPI_ARB_TIMEOUT_EN is defined.
module tb_qspi_arbiter;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        aresetn = 1'b1;
  logic        rv [2];
  logic [23:0] ra [2];
  logic        rr [2];
  logic        m0_req_ready, m1_req_ready;
  logic        m0_rsp_valid, m1_rsp_valid;
  logic [31:0] m0_rsp_data, m1_rsp_data;
  logic        m0_rsp_err, m1_rsp_err;
  logic [23:0] qspi_addr;
  logic        qspi_read_en, qspi_rready;
  logic [31:0] qspi_dout;
  logic        qspi_dval;
  logic        resp_dval = 1'b0, man_dval = 1'b0;
  logic [31:0] resp_dout = '0, man_dout = '0;

  assign qspi_dval = resp_dval | man_dval;
  assign qspi_dout = resp_dout | man_dout;

  always #5 clk = ~clk;

  qspi_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .aclk(clk), .aresetn(aresetn),
    .m0_req_valid(rv[0]), .m0_req_ready(m0_req_ready),
    .m0_req_addr(ra[0]), .m0_rsp_valid(m0_rsp_valid),
    .m0_rsp_ready(rr[0]), .m0_rsp_data(m0_rsp_data),
    .m0_rsp_err(m0_rsp_err),
    .m1_req_valid(rv[1]), .m1_req_ready(m1_req_ready),
    .m1_req_addr(ra[1]), .m1_rsp_valid(m1_rsp_valid),
    .m1_rsp_ready(rr[1]), .m1_rsp_data(m1_rsp_data),
    .m1_rsp_err(m1_rsp_err),
    .qspi_addr(qspi_addr), .qspi_read_en(qspi_read_en),
    .qspi_dout(qspi_dout), .qspi_dval(qspi_dval),
    .qspi_rready(qspi_rready)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Logs of observed events, consumed by the directed cases
  int          grant_log [$];
  logic [23:0] addr_log [$];
  int          rsp_id_log [$];
  logic [31:0] rsp_data_log [$];
  logic        rsp_err_log [$];

  // Transaction-level model: one outstanding request, cycles counted from handshake
  bit          started = 0;
  bit          m_busy = 0, m_got = 0, m_last = 1, m_gnt = 0, m_err = 0;
  int          m_cyc = 0, m_wc = 0;
  logic [23:0] m_addr = '0;
  logic [31:0] m_data = '0;

  always @(negedge clk) begin
    bit e_rdy0, e_rdy1, in_issue, in_wait, in_resp;
    if (m_busy) m_cyc++;
    e_rdy0   = !m_busy && rv[0] && (!rv[1] || m_last);
    e_rdy1   = !m_busy && rv[1] && (!rv[0] || !m_last);
    in_issue = m_busy && m_cyc == 1;
    in_wait  = m_busy && m_cyc >= 2 && !m_got;
    in_resp  = m_busy && m_got;
    if (started) begin
      chk("m0_req_ready", 32'(m0_req_ready), 32'(e_rdy0));
      chk("m1_req_ready", 32'(m1_req_ready), 32'(e_rdy1));
      chk("qspi_read_en", 32'(qspi_read_en), 32'(in_issue));
      chk("qspi_rready", 32'(qspi_rready), 32'(in_wait));
      chk("qspi_addr", 32'(qspi_addr),
          (in_issue || in_wait) ? 32'(m_addr) : 32'h0);
      chk("m0_rsp_valid", 32'(m0_rsp_valid), 32'(in_resp && !m_gnt));
      chk("m1_rsp_valid", 32'(m1_rsp_valid), 32'(in_resp && m_gnt));
      chk("m0_rsp_data", m0_rsp_data, (in_resp && !m_gnt) ? m_data : 32'h0);
      chk("m1_rsp_data", m1_rsp_data, (in_resp && m_gnt) ? m_data : 32'h0);
      chk("m0_rsp_err", 32'(m0_rsp_err), 32'(in_resp && !m_gnt && m_err));
      chk("m1_rsp_err", 32'(m1_rsp_err), 32'(in_resp && m_gnt && m_err));
    end
    if (qspi_read_en) addr_log.push_back(qspi_addr);
    if (m0_req_ready && rv[0]) grant_log.push_back(0);
    if (m1_req_ready && rv[1]) grant_log.push_back(1);
    if (m0_rsp_valid && rr[0]) begin
      rsp_id_log.push_back(0);
      rsp_data_log.push_back(m0_rsp_data);
      rsp_err_log.push_back(m0_rsp_err);
    end
    if (m1_rsp_valid && rr[1]) begin
      rsp_id_log.push_back(1);
      rsp_data_log.push_back(m1_rsp_data);
      rsp_err_log.push_back(m1_rsp_err);
    end
    if (!aresetn) begin
      m_busy = 0; m_got = 0; m_last = 1; m_err = 0;
    end else if (!m_busy) begin
      if (e_rdy0 || e_rdy1) begin
        m_busy = 1; m_got = 0; m_cyc = 0; m_wc = 0;
        m_gnt  = e_rdy1;
        m_addr = e_rdy0 ? ra[0] : ra[1];
      end
    end else if (in_wait) begin
      if (qspi_dval) begin
        m_got = 1; m_data = qspi_dout; m_err = 0;
      end
`ifdef QSPI_ARB_TIMEOUT_EN
      else begin
        m_wc++;
        if (m_wc == TO) begin
          m_got = 1; m_data = '0; m_err = 1;
        end
      end
`endif
    end else if (in_resp && rr[m_gnt]) begin
      m_busy = 0; m_got = 0; m_last = m_gnt;
    end
  end

  // Flash responder: answers each read pulse after dly cycles
  int          dly = 3;
  bit          resp_en = 1;
  logic [23:0] resp_a;

  initial begin
    forever begin
      @(negedge clk);
      if (resp_en && qspi_read_en) begin
        resp_a = qspi_addr;
        repeat (dly) @(posedge clk);
        #1;
        resp_dval = 1'b1;
        resp_dout = (resp_a == 24'h100) ? 32'hCAFEBABE : {8'hA5, resp_a};
        @(posedge clk);
        #1;
        resp_dval = 1'b0;
        resp_dout = '0;
      end
    end
  end

  task automatic clear_logs();
    grant_log.delete(); addr_log.delete();
    rsp_id_log.delete(); rsp_data_log.delete(); rsp_err_log.delete();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    aresetn = 1'b0;
    rv[0] = 0; rv[1] = 0;
    repeat (2) @(posedge clk);
    #1;
    aresetn = 1'b1;
    started = 1;
    clear_logs();
  endtask

  task automatic do_req(input int m, input logic [23:0] a,
                        output int waited);
    bit hs = 0;
    waited = 0;
    rv[m] = 1'b1;
    ra[m] = a;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if ((m == 0) ? m0_req_ready : m1_req_ready) begin
        hs = 1;
        break;
      end
      waited++;
    end
    chk($sformatf("req_handshake_m%0d", m), 32'(hs), 32'd1);
    @(posedge clk);
    #1;
    rv[m] = 1'b0;
  endtask

  task automatic wait_rsp(input int n, input int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (rsp_id_log.size() >= n) begin
        ok = 1;
        break;
      end
    end
    chk($sformatf("rsp_count_%0d", n), 32'(ok), 32'd1);
    #1;
  endtask

  int w0, w1;
  int exp_alt [6] = '{0, 1, 0, 1, 0, 1};
  bit seen;

  initial begin
    rv[0] = 0; rv[1] = 0; ra[0] = '0; ra[1] = '0;
    rr[0] = 1; rr[1] = 1;

    // Single m0 read, first cycle after reset, slow flash
    do_reset();
    dly = 10;
    do_req(0, 24'h000100, w0);
    chk("first_req_no_wait", 32'(w0), 32'd0);
    wait_rsp(1, 60);
    chk("t1_reads", 32'(addr_log.size()), 32'd1);
    chk("t1_addr", 32'(addr_log[0]), 32'h000100);
    chk("t1_id", 32'(rsp_id_log[0]), 32'd0);
    chk("t1_data", rsp_data_log[0], 32'hCAFEBABE);
    chk("t1_err", 32'(rsp_err_log[0]), 32'd0);

    // Simultaneous requests after reset: m0 first
    do_reset();
    dly = 2;
    fork
      do_req(0, 24'h10, w0);
      do_req(1, 24'h20, w1);
    join
    wait_rsp(2, 60);
    chk("t2_addr0", 32'(addr_log[0]), 32'h10);
    chk("t2_addr1", 32'(addr_log[1]), 32'h20);
    chk("t2_rsp1", rsp_data_log[1], 32'hA5000020);
    chk("t2_gnt0", 32'(grant_log[0]), 32'd0);
    chk("t2_gnt1", 32'(grant_log[1]), 32'd1);

    // Both continuously valid: strict alternation
    do_reset();
    dly = 1;
    ra[0] = 24'h60; ra[1] = 24'h70;
    rv[0] = 1; rv[1] = 1;
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (grant_log.size() >= 6) begin
        seen = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    rv[0] = 0; rv[1] = 0;
    chk("t3_six_grants", 32'(seen), 32'd1);
    wait_rsp(6, 60);
    for (int i = 0; i < 6; i++)
      chk($sformatf("t3_gnt%0d", i), 32'(grant_log[i]), 32'(exp_alt[i]));

    // m1 stalls its response: m0 must wait, no second read
    do_reset();
    dly = 2;
    rr[1] = 0;
    do_req(1, 24'h30, w1);
    fork
      do_req(0, 24'h40, w0);
    join_none
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (m1_rsp_valid) begin
        seen = 1;
        break;
      end
    end
    chk("t4_m1_rsp", 32'(seen), 32'd1);
    repeat (20) @(negedge clk);
    chk("t4_stall_grants", 32'(grant_log.size()), 32'd1);
    chk("t4_stall_reads", 32'(addr_log.size()), 32'd1);
    @(posedge clk);
    #1;
    rr[1] = 1;
    wait_rsp(2, 60);
    wait fork;
    chk("t4_gnt1", 32'(grant_log[1]), 32'd0);
    chk("t4_addr1", 32'(addr_log[1]), 32'h40);
    chk("t4_rsp0", rsp_data_log[0], 32'hA5000030);

    // Reset mid-WAIT, then a late dval
    do_reset();
    resp_en = 0;
    do_req(0, 24'h50, w0);
    repeat (3) @(posedge clk);
    #1;
    aresetn = 1'b0;
    @(posedge clk);
    #1;
    aresetn = 1'b1;
    man_dval = 1'b1;
    man_dout = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    man_dval = 1'b0;
    man_dout = '0;
    repeat (4) @(negedge clk);
    chk("t5_no_rsp", 32'(rsp_id_log.size()), 32'd0);
    chk("t5_rsp_valid", 32'({m1_rsp_valid, m0_rsp_valid}), 32'd0);
    chk("t5_rsp_data", m0_rsp_data | m1_rsp_data, 32'd0);
    chk("t5_qspi", 32'({qspi_read_en, qspi_rready}), 32'd0);
    chk("t5_qspi_addr", 32'(qspi_addr), 32'd0);
    @(posedge clk);
    #1;
    resp_en = 1;
    do_req(0, 24'h58, w0);
    chk("t5_idle_accept", 32'(w0), 32'd0);
    wait_rsp(1, 60);
    chk("t5_rsp_after", rsp_data_log[0], 32'hA5000058);

`ifdef QSPI_ARB_TIMEOUT_EN
    // No dval: timeout yields err=1, data 0
    do_reset();
    resp_en = 0;
    do_req(0, 24'h77, w0);
    wait_rsp(1, 60);
    chk("t6_err", 32'(rsp_err_log[0]), 32'd1);
    chk("t6_data", rsp_data_log[0], 32'd0);
    resp_en = 1;
`endif

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
